// File: rtl/rise_mon_pkg.sv
// Shared types and helpers for the rise event monitor.
package rise_mon_pkg;

  localparam int W_DEF     = 4;
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 8;

  // One queued event: which bits rose, and the cycle they rose on.
  typedef struct packed {
    logic [W_DEF-1:0]    mask;
    logic [TS_W_DEF-1:0] ts;
  } evt_t;

  // Increment that sticks at all-ones for a counter 'width' bits wide (width < 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] w_max;
    w_max = 32'hFFFF_FFFF >> (32 - width);
    return (value == w_max) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rise_evt_fifo.sv
// Synchronous event FIFO with one-bit-wider pointers for full/empty.
// The head is read straight from storage, so it only changes on a pop
// (or when the first entry lands in an empty FIFO).
module rise_evt_fifo
  import rise_mon_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = evt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  T     i_data,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_wr_en;
  logic        w_rd_en;

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance; reset discards whatever was queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rise_event_monitor.sv
// Rise event monitor: per-bit 0->1 detection on a sampled bus, timestamped
// events queued for a valid/ready consumer, bit-0 rise and drop counters.
// Define RISE_MONITOR_ASSERT_EN to compile the built-in SVA checks.
module rise_event_monitor
  import rise_mon_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 4,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     sample_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [W-1:0]     evt_mask_o,
  output logic [TS_W-1:0]  evt_ts_o,
  output logic [CNT_W-1:0] lsb_rise_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             ovf_o
);

  typedef struct packed {
    logic [W-1:0]    mask;
    logic [TS_W-1:0] ts;
  } evt_loc_t;

  logic [W-1:0]     r_sample_q;
  logic             r_prev_ok;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_lsb_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_ovf;

  logic [W-1:0]     w_raw;
  logic [W-1:0]     w_mask;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  evt_loc_t         w_push_evt;
  evt_loc_t         w_head;

  // Previous sample and whether it is trustworthy (only after an enabled edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_q <= '0;
      r_prev_ok  <= 1'b0;
    end else begin
      r_sample_q <= sample_i;
      r_prev_ok  <= en_i;
    end
  end

  // Rise mask; a bit counts only if it is a definite 1 now and was a definite 0.
  always_comb begin
    w_raw  = sample_i & ~r_sample_q;
    w_mask = '0;
    if (en_i && r_prev_ok) begin
      for (int i = 0; i < W; i++) begin
        w_mask[i] = (w_raw[i] === 1'b1);
      end
    end
  end

  assign w_push          = |w_mask;
  assign w_pop           = !w_empty && evt_ready_i;
  assign w_drop          = w_push && w_full && !w_pop;
  assign w_push_evt.mask = w_mask;
  assign w_push_evt.ts   = r_ts;

  rise_evt_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_loc_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_evt),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Free-running timestamp, untouched by enable or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  // Bit-0 rise count, drop count and sticky overflow; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsb_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (clr_i) begin
      r_lsb_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_mask[0]) r_lsb_cnt  <= CNT_W'(sat_inc(32'(r_lsb_cnt), CNT_W));
      if (w_drop) begin
        r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), CNT_W));
        r_ovf      <= 1'b1;
      end
    end
  end

  // Head fields read as zero whenever nothing is queued.
  assign evt_valid_o    = !w_empty;
  assign evt_mask_o     = w_empty ? '0 : w_head.mask;
  assign evt_ts_o       = w_empty ? '0 : w_head.ts;
  assign lsb_rise_cnt_o = r_lsb_cnt;
  assign drop_cnt_o     = r_drop_cnt;
  assign ovf_o          = r_ovf;

`ifdef RISE_MONITOR_ASSERT_EN
  a_lsb_push_is_rose: assert property (@(posedge clk) disable iff (!rst_n)
    (en_i && $past(en_i) && w_push && w_mask[0]) |-> $rose(sample_i[0]))
    else $error("bit-0 push without $rose(sample_i[0]) at %0t", $time);

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (evt_valid_o && !evt_ready_i) |=> $stable(evt_mask_o))
    else $error("evt_mask_o changed while stalled at %0t", $time);

  a_ovf_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(ovf_o) |-> $past(clr_i))
    else $error("ovf_o fell without clr_i at %0t", $time);
`else
`endif

endmodule

// File: tb/tb_rise_event_monitor.sv
// Directed bench for rise_event_monitor with hand-computed expectations.
module tb_rise_event_monitor;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sample_i;
  logic        en_i;
  logic        clr_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [3:0]  evt_mask_o;
  logic [15:0] evt_ts_o;
  logic [7:0]  lsb_rise_cnt_o;
  logic [7:0]  drop_cnt_o;
  logic        ovf_o;

  int checks;
  int errors;

  logic [3:0] xSample;
  logic [3:0] expMask;
  int         lsbExp;

  rise_event_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_i       (sample_i),
    .en_i           (en_i),
    .clr_i          (clr_i),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_mask_o     (evt_mask_o),
    .evt_ts_o       (evt_ts_o),
    .lsb_rise_cnt_o (lsb_rise_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .ovf_o          (ovf_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit rises only where the new value is a definite 1 and the old a definite 0.
  function automatic logic [3:0] riseOf(input logic [3:0] newV, input logic [3:0] oldV);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (newV[i] === 1'b1) && (oldV[i] === 1'b0);
    return r;
  endfunction

  // Drive one set of inputs, let one rising edge consume them, settle 1 time unit.
  task automatic applyStimulus(input logic [3:0] s, input logic en, input logic rdy, input logic clr);
    sample_i    = s;
    en_i        = en;
    evt_ready_i = rdy;
    clr_i       = clr;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check the head of the queue in one go.
  task automatic checkHead(input string tag, input logic [3:0] m, input int ts);
    checkOutput({tag, "_valid"}, 32'(evt_valid_o), 32'd1);
    checkOutput({tag, "_mask"}, 32'(evt_mask_o), 32'(m));
    checkOutput({tag, "_ts"}, 32'(evt_ts_o), 32'(ts));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    sample_i    = 4'b0000;
    en_i        = 1'b1;
    clr_i       = 1'b0;
    evt_ready_i = 1'b1;
    xSample     = 4'b101x;

    #2;
    checkOutput("rst_valid", 32'(evt_valid_o), 32'd0);
    checkOutput("rst_lsb", 32'(lsb_rise_cnt_o), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_o), 32'd0);
    #10 rst_n = 1'b1;

    // Basic rises, ready held high; edge index equals timestamp.
    applyStimulus(4'b1000, 1, 1, 0);                       // e0: first enabled edge
    checkOutput("e0_valid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b1001, 1, 1, 0);                       // e1
    checkHead("e1", 4'b0001, 1);
    checkOutput("e1_lsb", 32'(lsb_rise_cnt_o), 32'd1);
    applyStimulus(4'b1011, 1, 1, 0);                       // e2
    checkHead("e2", 4'b0010, 2);
    applyStimulus(4'b1111, 1, 1, 0);                       // e3
    checkHead("e3", 4'b0100, 3);
    applyStimulus(4'b1111, 1, 1, 0);                       // e4
    checkOutput("e4_valid", 32'(evt_valid_o), 32'd0);
    checkOutput("e4_lsb", 32'(lsb_rise_cnt_o), 32'd1);
    lsbExp = 1;

    // Unknown bit: a bit sampled as X never counts as the "before 0" of a rise.
    applyStimulus(xSample, 1, 1, 0);                       // e5
    checkOutput("e5_valid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b1111, 1, 1, 0);                       // e6
    expMask = riseOf(4'b1111, xSample);
    lsbExp  = lsbExp + int'(expMask[0]);
    checkHead("e6", expMask, 6);
    checkOutput("e6_lsb", 32'(lsb_rise_cnt_o), 32'(lsbExp));
    applyStimulus(4'b1111, 1, 1, 0);                       // e7
    checkOutput("e7_valid", 32'(evt_valid_o), 32'd0);

    // Stall: six rising edges into a four-entry FIFO.
    applyStimulus(4'b0101, 1, 0, 0);                       // e8: no rise
    checkOutput("e8_valid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b1010, 1, 0, 0);                       // e9
    checkHead("e9", 4'b1010, 9);
    applyStimulus(4'b0101, 1, 0, 0);                       // e10
    checkHead("e10_hold", 4'b1010, 9);
    applyStimulus(4'b1010, 1, 0, 0);                       // e11
    applyStimulus(4'b0101, 1, 0, 0);                       // e12: now full
    checkOutput("e12_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("e12_ovf", 32'(ovf_o), 32'd0);
    applyStimulus(4'b1010, 1, 0, 0);                       // e13: dropped
    checkOutput("e13_drop", 32'(drop_cnt_o), 32'd1);
    checkOutput("e13_ovf", 32'(ovf_o), 32'd1);
    applyStimulus(4'b0101, 1, 0, 0);                       // e14: dropped
    lsbExp = lsbExp + 3;
    checkHead("e14_hold", 4'b1010, 9);
    checkOutput("e14_drop", 32'(drop_cnt_o), 32'd2);
    checkOutput("e14_lsb", 32'(lsb_rise_cnt_o), 32'(lsbExp));

    // Full with a push and a pop on the same edge: nothing dropped.
    applyStimulus(4'b1010, 1, 1, 0);                       // e15
    checkHead("e15", 4'b0101, 10);
    checkOutput("e15_drop", 32'(drop_cnt_o), 32'd2);
    applyStimulus(4'b1010, 1, 1, 0);                       // e16
    checkHead("e16", 4'b1010, 11);
    applyStimulus(4'b1010, 1, 1, 0);                       // e17
    checkHead("e17", 4'b0101, 12);
    applyStimulus(4'b1010, 1, 1, 0);                       // e18
    checkHead("e18", 4'b1010, 15);
    applyStimulus(4'b1010, 1, 1, 0);                       // e19
    checkOutput("e19_valid", 32'(evt_valid_o), 32'd0);
    checkOutput("e19_ovf", 32'(ovf_o), 32'd1);

    // Clear coinciding with a bit-0 rise; queued entries survive.
    applyStimulus(4'b0000, 1, 0, 0);                       // e20
    applyStimulus(4'b0001, 1, 0, 0);                       // e21
    lsbExp = lsbExp + 1;
    checkOutput("e21_lsb", 32'(lsb_rise_cnt_o), 32'(lsbExp));
    applyStimulus(4'b0000, 1, 0, 0);                       // e22
    applyStimulus(4'b0001, 1, 0, 1);                       // e23
    checkOutput("e23_lsb", 32'(lsb_rise_cnt_o), 32'd0);
    checkOutput("e23_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("e23_ovf", 32'(ovf_o), 32'd0);
    checkHead("e23", 4'b0001, 21);
    applyStimulus(4'b0001, 1, 1, 0);                       // e24: pop
    checkHead("e24", 4'b0001, 23);

    // Asynchronous reset mid-drain.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(evt_valid_o), 32'd0);
    checkOutput("mid_rst_mask", 32'(evt_mask_o), 32'd0);
    checkOutput("mid_rst_ts", 32'(evt_ts_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0001, 1, 1, 0);                       // r0: no fresh history
    checkOutput("r0_valid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b0000, 1, 1, 0);                       // r1
    applyStimulus(4'b0001, 1, 1, 0);                       // r2
    checkHead("r2", 4'b0001, 2);
    applyStimulus(4'b0000, 0, 1, 0);                       // r3: disabled edge
    checkOutput("r3_valid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b0001, 1, 1, 0);                       // r4: history invalidated
    checkOutput("r4_valid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b0000, 1, 1, 0);                       // r5
    applyStimulus(4'b0001, 1, 1, 0);                       // r6
    checkHead("r6", 4'b0001, 6);
    checkOutput("r6_lsb", 32'(lsb_rise_cnt_o), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
